// File: rtl/lpgbt_uplink_frame_tx.sv
// rtl/lpgbt_uplink_frame_tx.sv - lpGBT uplink frame builder with CRC-16 and 8 x 32-bit TX gearbox
// Frame layout {HEADER, IC, EC, user data, CRC-16}; CRC is folded in word by word while the frame drains.

module lpgbt_crc16_ccitt #(
   parameter int DATA_W = 32
) (
   input  logic [15:0]       crc_in,
   input  logic [DATA_W-1:0] data,
   output logic [15:0]       crc_out
);
   // MSB-first, polynomial 0x1021, no reflection
   always_comb begin
      logic [15:0] c;
      c = crc_in;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
      end
      crc_out = c;
   end
endmodule

module lpgbt_uplink_frame_tx #(
   parameter logic [1:0]  HEADER          = 2'b10,
   parameter logic [15:0] CRC_INIT        = 16'hFFFF,
   parameter int          WORDS_PER_FRAME = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         invert_i,
   input  logic [233:0] user_data_i,
   input  logic [1:0]   ic_i,
   input  logic [1:0]   ec_i,
   input  logic         frame_valid_i,
   output logic         frame_ready_o,
   output logic [31:0]  word_o,
   output logic         word_valid_o,
   input  logic         word_ready_i,
   output logic [31:0]  frame_count_o,
   output logic         busy_o
);
   generate
      if (WORDS_PER_FRAME != 8) begin : g_bad_words_per_frame
         $error("lpgbt_uplink_frame_tx supports only WORDS_PER_FRAME = 8");
      end
   endgenerate

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   state_t           state_next;
   logic [239:0]     frame_reg;
   logic [15:0]      crc_reg;
   logic [15:0]      crc_word;
   logic [15:0]      crc_last;
   logic [2:0]       idx;
   logic [31:0]      frame_cnt;
   logic [31:0]      frame_cnt_next;
   logic [7:0][31:0] line_words;
   logic [31:0]      word_cur;
   logic [31:0]      word_sel;
   logic             frame_hs;
   logic             word_hs;
   logic             last_word;

   assign last_word = (idx == 3'd7);
   assign frame_hs  = frame_valid_i && frame_ready_o;
   assign word_hs   = word_valid_o && word_ready_i;

   // Word 7 carries the tail of the payload plus the CRC finished over that tail
   lpgbt_crc16_ccitt #(.DATA_W(16)) u_crc_last (
      .crc_in  (crc_reg),
      .data    (frame_reg[15:0]),
      .crc_out (crc_last)
   );

   assign line_words = {frame_reg, crc_last};
   assign word_cur   = line_words[3'd7 - idx];

   lpgbt_crc16_ccitt #(.DATA_W(32)) u_crc_word (
      .crc_in  (crc_reg),
      .data    (word_cur),
      .crc_out (crc_word)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame_hs) state_next = SEND;
         SEND:    if (word_hs && last_word && !frame_hs) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Reset gates frame_ready so nothing is accepted while the block is held in reset
   always_comb begin
      frame_ready_o = 1'b0;
      word_valid_o  = 1'b0;
      busy_o        = 1'b0;
      word_sel      = '0;
      case (state)
         IDLE: frame_ready_o = enable_i && !rst_i;
         SEND: begin
            frame_ready_o = enable_i && last_word && word_ready_i && !rst_i;
            word_valid_o  = 1'b1;
            busy_o        = 1'b1;
            word_sel      = word_cur;
         end
         default: ;
      endcase
   end

   assign word_o = word_sel ^ {32{invert_i}};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_reg <= '0;
         crc_reg   <= CRC_INIT;
         idx       <= '0;
      end else if (frame_hs) begin
         frame_reg <= {HEADER, ic_i, ec_i, user_data_i};
         crc_reg   <= CRC_INIT;
         idx       <= '0;
      end else if (word_hs) begin
         idx     <= idx + 3'd1;
         crc_reg <= crc_word;
      end
   end

   assign frame_cnt_next = frame_cnt + {31'd0, word_hs && last_word};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_cnt <= '0;
      end else begin
         frame_cnt <= frame_cnt_next;
      end
   end

   assign frame_count_o = frame_cnt;

endmodule

// File: tb/tb_lpgbt_uplink_frame_tx.sv
// tb/tb_lpgbt_uplink_frame_tx.sv - self-checking bench for lpgbt_uplink_frame_tx
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_lpgbt_uplink_frame_tx;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         enable_i = 1'b1;
   logic         invert_i = 1'b0;
   logic [233:0] user_data_i = '0;
   logic [1:0]   ic_i = '0;
   logic [1:0]   ec_i = '0;
   logic         frame_valid_i = 1'b0;
   logic         frame_ready_o;
   logic [31:0]  word_o;
   logic         word_valid_o;
   logic         word_ready_i = 1'b1;
   logic [31:0]  frame_count_o;
   logic         busy_o;

   always #5 clk_i = ~clk_i;

   lpgbt_uplink_frame_tx dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .invert_i      (invert_i),
      .user_data_i   (user_data_i),
      .ic_i          (ic_i),
      .ec_i          (ec_i),
      .frame_valid_i (frame_valid_i),
      .frame_ready_o (frame_ready_o),
      .word_o        (word_o),
      .word_valid_o  (word_valid_o),
      .word_ready_i  (word_ready_i),
      .frame_count_o (frame_count_o),
      .busy_o        (busy_o)
   );

   typedef struct {
      logic [233:0] ud;
      logic [1:0]   ic;
      logic [1:0]   ec;
      logic         inv;
      logic [31:0]  w0;
      logic [31:0]  w6;
      logic [15:0]  w7hi;
   } vec_t;

   int          n_checks = 0;
   int          n_pass = 0;
   int          pos = 0;
   int          word_total = 0;
   int          cyc = 0;
   int          stall_left = 0;
   int          hs_cyc[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_count = '0;
   logic [31:0] cnt_offset = '0;
   logic [31:0] prev_raw = '0;
   logic [31:0] got_words[8];
   logic [31:0] ref_words[8];
   logic        prev_rst = 1'b0;
   logic        prev_fhs = 1'b0;
   logic        prev_stall = 1'b0;
   logic        last_fhs = 1'b0;
   logic        sink_rand = 1'b0;
   logic        inv_rand = 1'b0;
   logic        stall_armed = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [15:0] crc_bits(input logic [255:0] d, input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = n - 1; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = c << 1;
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   function automatic logic [255:0] model_frame(input logic [233:0] ud, input logic [1:0] ic,
                                                input logic [1:0] ec);
      logic [255:0] f;
      f = {2'b10, ic, ec, ud, 16'h0000};
      f[15:0] = crc_bits(f >> 16, 240);
      return f;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   task automatic monitor();
      logic [31:0]  raw;
      logic [31:0]  exp_w;
      logic [255:0] f;
      logic         fhs;
      logic         whs;
      cyc++;
      raw = word_o ^ {32{invert_i}};
      if (rst_i) begin
         chk("ready_in_reset", 32'(frame_ready_o), 32'd0);
         exp_q.delete();
         pos = 0;
         exp_count = '0;
         prev_fhs = 1'b0;
         prev_stall = 1'b0;
         last_fhs = 1'b0;
      end else begin
         chk("frame_count", frame_count_o, exp_count + cnt_offset);
         chk("busy_vs_valid", 32'(busy_o), 32'(word_valid_o));
         if (prev_rst) chk("valid_after_reset", 32'(word_valid_o), 32'd0);
         if (prev_fhs || pos != 0) chk("valid_in_frame", 32'(word_valid_o), 32'd1);
         if (prev_stall) chk("stall_hold", raw, prev_raw);
         if (word_valid_o)
            chk("ready_send", 32'(frame_ready_o), 32'(enable_i && pos == 7 && word_ready_i));
         else
            chk("ready_idle", 32'(frame_ready_o), 32'(enable_i));
         fhs = frame_valid_i && frame_ready_o;
         whs = word_valid_o && word_ready_i;
         if (whs) begin
            if (exp_q.size() > 0) exp_w = exp_q.pop_front();
            else exp_w = ~raw;
            chk($sformatf("word%0d", pos), raw, exp_w);
            got_words[pos] = word_o;
            word_total++;
            hs_cyc.push_back(cyc);
            if (pos == 7) begin
               pos = 0;
               exp_count++;
            end else begin
               pos++;
            end
         end
         if (fhs) begin
            f = model_frame(user_data_i, ic_i, ec_i);
            for (int k = 0; k < 8; k++) exp_q.push_back(f[255 - 32*k -: 32]);
         end
         prev_stall = word_valid_o && !word_ready_i;
         prev_raw = raw;
         prev_fhs = fhs;
         last_fhs = fhs;
      end
      prev_rst = rst_i;
   endtask

   task automatic drive();
      if (stall_left > 0) begin
         word_ready_i = 1'b0;
         stall_left--;
      end else if (stall_armed && pos == 3 && word_valid_o) begin
         stall_armed = 1'b0;
         stall_left = 4;
         word_ready_i = 1'b0;
      end else begin
         word_ready_i = sink_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
      if (inv_rand && $urandom_range(0, 3) == 0) invert_i = ~invert_i;
   endtask

   task automatic cycle();
      @(negedge clk_i);
      monitor();
      @(posedge clk_i);
      #1;
      drive();
   endtask

   task automatic offer(input logic [233:0] ud, input logic [1:0] ic, input logic [1:0] ec,
                        input bit keep);
      logic [255:0] r;
      bit           done;
      done = 1'b0;
      frame_valid_i = 1'b1;
      user_data_i = ud;
      ic_i = ic;
      ec_i = ec;
      for (int t = 0; t < 400 && !done; t++) begin
         cycle();
         done = last_fhs;
      end
      chk("offer_accepted", 32'(done), 32'd1);
      if (!keep) frame_valid_i = 1'b0;
      r = rand256();
      user_data_i = r[233:0];
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 800 && !done; t++) begin
         cycle();
         done = !word_valid_o && exp_q.size() == 0;
      end
      chk("idle_reached", 32'(done), 32'd1);
   endtask

   task automatic wait_pos(input int n);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         cycle();
         done = (pos == n) && word_valid_o;
      end
      chk("pos_reached", 32'(done), 32'd1);
   endtask

   initial begin
      vec_t         vecs[4];
      logic [255:0] r;
      logic [255:0] s;
      logic [31:0]  cnt0;
      int           w_start;
      bit           seen;

      vecs[0] = '{234'd0, 2'b11, 2'b01, 1'b0, 32'hB400_0000, 32'h0000_0000, 16'h0000};
      vecs[1] = '{234'd0, 2'b11, 2'b01, 1'b1, 32'h4BFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF};
      vecs[2] = '{{234{1'b1}}, 2'b00, 2'b00, 1'b0, 32'h83FF_FFFF, 32'hFFFF_FFFF, 16'hFFFF};
      vecs[3] = '{234'd1, 2'b10, 2'b10, 1'b0, 32'hA800_0000, 32'h0000_0000, 16'h0001};

      repeat (3) cycle();
      chk("reset_word_valid", 32'(word_valid_o), 32'd0);
      chk("reset_word", word_o, 32'd0);
      chk("reset_count", frame_count_o, 32'd0);
      chk("reset_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b0;

      s = '0;
      s[71:0] = 72'h31_32_33_34_35_36_37_38_39;
      chk("model_crc_check_string", 32'(crc_bits(s, 72)), 32'h0000_29B1);

      for (int i = 0; i < 4; i++) begin
         invert_i = vecs[i].inv;
         offer(vecs[i].ud, vecs[i].ic, vecs[i].ec, 1'b0);
         wait_idle();
         chk($sformatf("vec%0d_w0", i), got_words[0], vecs[i].w0);
         chk($sformatf("vec%0d_w6", i), got_words[6], vecs[i].w6);
         chk($sformatf("vec%0d_w7hi", i), 32'(got_words[7][31:16]), 32'(vecs[i].w7hi));
         if (i == 0) ref_words = got_words;
         if (i == 1) chk("inverted_word7", got_words[7], ~ref_words[7]);
      end
      invert_i = 1'b0;
      chk("count_after_table", frame_count_o, 32'd4);

      cnt0 = frame_count_o;
      w_start = word_total;
      for (int i = 0; i < 4; i++) begin
         r = rand256();
         offer(r[233:0], r[235:234], r[237:236], i < 3);
      end
      wait_idle();
      chk("b2b_words", 32'(word_total - w_start), 32'd32);
      if (word_total >= w_start + 32)
         chk("b2b_no_bubble", 32'(hs_cyc[w_start + 31] - hs_cyc[w_start]), 32'd31);
      chk("b2b_count", frame_count_o - cnt0, 32'd4);

      sink_rand = 1'b1;
      inv_rand = 1'b1;
      for (int i = 0; i < 6; i++) begin
         r = rand256();
         offer(r[233:0], r[235:234], r[237:236], 1'b0);
         stall_armed = 1'b1;
      end
      wait_idle();
      inv_rand = 1'b0;
      invert_i = 1'b0;
      stall_armed = 1'b1;
      offer(vecs[0].ud, vecs[0].ic, vecs[0].ec, 1'b0);
      wait_idle();
      for (int k = 0; k < 8; k++) chk($sformatf("stalled_w%0d", k), got_words[k], ref_words[k]);
      sink_rand = 1'b0;
      stall_armed = 1'b0;

      cnt0 = frame_count_o;
      r = rand256();
      offer(r[233:0], r[235:234], r[237:236], 1'b1);
      wait_pos(2);
      enable_i = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 100 && word_valid_o; t++) begin
         cycle();
         seen = seen | frame_ready_o;
      end
      cycle();
      chk("disable_no_ready", 32'(seen), 32'd0);
      chk("disable_frame_done", frame_count_o - cnt0, 32'd1);
      chk("disable_stays_idle", 32'(word_valid_o), 32'd0);
      frame_valid_i = 1'b0;
      enable_i = 1'b1;

      r = rand256();
      offer(r[233:0], r[235:234], r[237:236], 1'b0);
      wait_pos(5);
      rst_i = 1'b1;
      cycle();
      chk("abort_valid", 32'(word_valid_o), 32'd0);
      chk("abort_count", frame_count_o, 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b0;
      r = rand256();
      offer(r[233:0], r[235:234], r[237:236], 1'b0);
      wait_idle();
      chk("count_after_abort", frame_count_o, 32'd1);

      force dut.frame_cnt = 32'hFFFF_FFFF;
      cnt_offset = 32'hFFFF_FFFF - exp_count;
      cycle();
      release dut.frame_cnt;
      cycle();
      chk("wrap_preload", frame_count_o, 32'hFFFF_FFFF);
      r = rand256();
      offer(r[233:0], r[235:234], r[237:236], 1'b0);
      wait_idle();
      chk("wrap_count", frame_count_o, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
